// File: rtl/render_pkg.sv
// Shared definitions for the scroll frame renderer: FSM state encoding,
// scroll-offset range derivation and the address-width helper.
package render_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BG    = 3'd1,
      ST_SPR   = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Bits needed to address n items; never less than one bit.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Largest legal background offset: the window must stay inside a ROM row.
   function automatic int max_offset(input int world_w, input int screen_w);
      return world_w - screen_w;
   endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row raster counter, column fastest. Wraps to (0,0) after the last
// position; 'last' flags the final position of the raster.
module raster_counter
   import render_pkg::*;
#(
   parameter int W = 160,
   parameter int H = 120
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 enable,
   input  logic                 clear,
   output logic [addr_w(W)-1:0] col,
   output logic [addr_w(H)-1:0] row,
   output logic                 last
);

   localparam int CW = addr_w(W);
   localparam int RW = addr_w(H);

   logic [CW-1:0] col_reg;
   logic [RW-1:0] row_reg;
   logic          col_end;
   logic          row_end;

   assign col_end = (col_reg == CW'(W - 1));
   assign row_end = (row_reg == RW'(H - 1));
   assign last    = col_end && row_end;
   assign col     = col_reg;
   assign row     = row_reg;

   // Advance one raster position per enabled cycle; clear has priority.
   always_ff @(posedge clk) begin
      if (!resetn || clear) begin
         col_reg <= '0;
         row_reg <= '0;
      end else if (enable) begin
         if (col_end) begin
            col_reg <= '0;
            row_reg <= row_end ? '0 : row_reg + RW'(1);
         end else begin
            col_reg <= col_reg + CW'(1);
         end
      end
   end

endmodule

// File: rtl/scroll_frame_renderer.sv
// Renders one frame per start pulse: a scrolling background window read from
// a wide ROM, then a clipped, colour-keyed sprite on top. Addresses go out one
// per cycle; the pixel pipeline lines coordinates up with the ROM data.
module scroll_frame_renderer
   import render_pkg::*;
#(
   parameter int SCREEN_W    = 160,
   parameter int SCREEN_H    = 120,
   parameter int WORLD_W     = 2000,
   parameter int SPR_W       = 15,
   parameter int SPR_H       = 16,
   parameter int COLOR_W     = 3,
   parameter int TRANSPARENT = 0
) (
   input  logic                                  clk,
   input  logic                                  resetn,
   input  logic                                  start,
   input  logic [addr_w(WORLD_W)-1:0]            scroll_step,
   input  logic [addr_w(SCREEN_W)-1:0]           spr_x,
   input  logic [addr_w(SCREEN_H)-1:0]           spr_y,
   output logic [addr_w(WORLD_W*SCREEN_H)-1:0]   bg_addr,
   input  logic [COLOR_W-1:0]                    bg_data,
   output logic [addr_w(SPR_W*SPR_H)-1:0]        spr_addr,
   input  logic [COLOR_W-1:0]                    spr_data,
   output logic [addr_w(SCREEN_W)-1:0]           x,
   output logic [addr_w(SCREEN_H)-1:0]           y,
   output logic [COLOR_W-1:0]                    colour,
   output logic                                  plot,
   output logic                                  busy,
   output logic                                  frame_done
);

   localparam int XW     = addr_w(WORLD_W);
   localparam int XS     = addr_w(SCREEN_W);
   localparam int YS     = addr_w(SCREEN_H);
   localparam int BAW    = addr_w(WORLD_W * SCREEN_H);
   localparam int SAW    = addr_w(SPR_W * SPR_H);
   localparam int SCW    = addr_w(SPR_W);
   localparam int SRW    = addr_w(SPR_H);
   localparam int PXW    = addr_w(SCREEN_W + SPR_W);
   localparam int PYW    = addr_w(SCREEN_H + SPR_H);
   localparam int MAXOFF = max_offset(WORLD_W, SCREEN_W);

   state_t state_reg;
   state_t state_next;

   logic bg_en;
   logic spr_en;
   logic cnt_clear;

   logic [XS-1:0]  bg_col;
   logic [YS-1:0]  bg_row;
   logic           bg_last;
   logic [SCW-1:0] spr_col;
   logic [SRW-1:0] spr_row;
   logic           spr_last;

   logic [XW-1:0]  offset_reg;
   logic [XW:0]    offset_sum;
   logic [XW:0]    offset_wrap;
   logic [XW-1:0]  offset_next;

   logic [XS-1:0]  spr_x_reg;
   logic [YS-1:0]  spr_y_reg;
   logic [PXW-1:0] spr_px;
   logic [PYW-1:0] spr_py;
   logic           in_bounds;

   logic           pipe_valid_reg;
   logic           pipe_spr_reg;
   logic [XS-1:0]  x_reg;
   logic [YS-1:0]  y_reg;
   logic           frame_done_reg;

   raster_counter #(.W(SCREEN_W), .H(SCREEN_H)) u_bg_cnt (
      .clk    (clk),
      .resetn (resetn),
      .enable (bg_en),
      .clear  (cnt_clear),
      .col    (bg_col),
      .row    (bg_row),
      .last   (bg_last)
   );

   raster_counter #(.W(SPR_W), .H(SPR_H)) u_spr_cnt (
      .clk    (clk),
      .resetn (resetn),
      .enable (spr_en),
      .clear  (cnt_clear),
      .col    (spr_col),
      .row    (spr_row),
      .last   (spr_last)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!resetn) state_reg <= ST_IDLE;
      else         state_reg <= state_next;
   end

   // FSM next-state logic: start is only honoured while idle.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (start)    state_next = ST_BG;
         ST_BG:    if (bg_last)  state_next = ST_SPR;
         ST_SPR:   if (spr_last) state_next = ST_FLUSH;
         ST_FLUSH: state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // FSM outputs: counter enables, counter clear and busy.
   always_comb begin
      bg_en     = (state_reg == ST_BG);
      spr_en    = (state_reg == ST_SPR);
      cnt_clear = (state_reg == ST_IDLE);
      busy      = (state_reg != ST_IDLE);
   end

   // Offset update computed one bit wider so the sum cannot overflow before the wrap compare.
   always_comb begin
      offset_sum  = {1'b0, offset_reg} + {1'b0, scroll_step};
      offset_wrap = offset_sum - (XW + 1)'(MAXOFF + 1);
      offset_next = (offset_sum <= (XW + 1)'(MAXOFF)) ? offset_sum[XW-1:0] : offset_wrap[XW-1:0];
   end

   // Scroll offset advances once per frame, sampling scroll_step only in DONE.
   always_ff @(posedge clk) begin
      if (!resetn)                  offset_reg <= '0;
      else if (state_reg == ST_DONE) offset_reg <= offset_next;
   end

   // Sprite position is captured when a frame is accepted and held for the whole frame.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         spr_x_reg <= '0;
         spr_y_reg <= '0;
      end else if (state_reg == ST_IDLE && start) begin
         spr_x_reg <= spr_x;
         spr_y_reg <= spr_y;
      end
   end

   // Address generation and sprite clipping for the pixel currently being issued.
   always_comb begin
      spr_px    = PXW'(spr_x_reg) + PXW'(spr_col);
      spr_py    = PYW'(spr_y_reg) + PYW'(spr_row);
      in_bounds = (spr_px < PXW'(SCREEN_W)) && (spr_py < PYW'(SCREEN_H));
      bg_addr   = bg_en ? (BAW'(offset_reg) + BAW'(bg_col) + BAW'(bg_row) * BAW'(WORLD_W)) : '0;
      spr_addr  = spr_en ? (SAW'(spr_row) * SAW'(SPR_W) + SAW'(spr_col)) : '0;
   end

   // One-stage pixel pipeline matching the ROM read latency, plus the frame_done pulse.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pipe_valid_reg <= 1'b0;
         pipe_spr_reg   <= 1'b0;
         x_reg          <= '0;
         y_reg          <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         pipe_valid_reg <= bg_en || (spr_en && in_bounds);
         pipe_spr_reg   <= spr_en;
         x_reg          <= bg_en ? bg_col : spr_px[XS-1:0];
         y_reg          <= bg_en ? bg_row : spr_py[YS-1:0];
         frame_done_reg <= (state_reg == ST_DONE);
      end
   end

   // VGA write port: colour comes straight from the ROM that was addressed last cycle;
   // transparent sprite pixels are dropped here because their data only arrives now.
   always_comb begin
      x          = x_reg;
      y          = y_reg;
      frame_done = frame_done_reg;
      colour     = pipe_valid_reg ? (pipe_spr_reg ? spr_data : bg_data) : '0;
      plot       = pipe_valid_reg && !(pipe_spr_reg && spr_data == COLOR_W'(TRANSPARENT));
   end

endmodule

// File: tb/tb_scroll_frame_renderer.sv
// Self-checking bench for scroll_frame_renderer: ROM models, a frame-level
// reference model and one task per scenario.
module tb_scroll_frame_renderer;

   localparam int SW     = 160;
   localparam int SH     = 120;
   localparam int WW     = 2000;
   localparam int PW     = 15;
   localparam int PH     = 16;
   localparam int NBG    = SW * SH;
   localparam int NSPR   = PW * PH;
   localparam int LAST_K = NBG + NSPR + 3;

   typedef struct {
      int k;
      int x;
      int y;
      int c;
      int ba;
      int sa;
   } rec_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [10:0] scroll_step = '0;
   logic [7:0]  spr_x = '0;
   logic [6:0]  spr_y = '0;
   logic [17:0] bg_addr;
   logic [2:0]  bg_data = '0;
   logic [7:0]  spr_addr;
   logic [2:0]  spr_data = '0;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        plot;
   logic        busy;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   logic [2:0] spr_mem [NSPR];
   rec_t obs_q[$];
   rec_t exp_q[$];
   int   done_q[$];
   logic busy_end;
   logic plot_after_abort;

   always #5 clk = ~clk;

   scroll_frame_renderer dut (
      .clk         (clk),
      .resetn      (resetn),
      .start       (start),
      .scroll_step (scroll_step),
      .spr_x       (spr_x),
      .spr_y       (spr_y),
      .bg_addr     (bg_addr),
      .bg_data     (bg_data),
      .spr_addr    (spr_addr),
      .spr_data    (spr_data),
      .x           (x),
      .y           (y),
      .colour      (colour),
      .plot        (plot),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   function automatic logic [2:0] bg_pix(input int a);
      return 3'((a * 5) ^ (a >> 4) ^ (a >> 9));
   endfunction

   // One-cycle-latency ROM models.
   always @(posedge clk) begin
      bg_data  <= bg_pix(int'(bg_addr));
      spr_data <= (int'(spr_addr) < NSPR) ? spr_mem[int'(spr_addr)] : 3'd0;
   end

   // Reference model: every plot a frame should produce, tagged with the cycle
   // (counted from the accepting edge) at which it appears on the write port.
   task automatic build_model(input int off, input int px, input int py, input int upto);
      rec_t r;
      int j;
      int a;
      exp_q.delete();
      for (int by = 0; by < SH; by++) begin
         for (int bx = 0; bx < SW; bx++) begin
            j = by * SW + bx;
            a = off + bx + by * WW;
            r = '{j + 2, bx, by, int'(bg_pix(a)), a, -1};
            if (r.k <= upto) exp_q.push_back(r);
         end
      end
      for (int sy = 0; sy < PH; sy++) begin
         for (int sx = 0; sx < PW; sx++) begin
            j = NBG + sy * PW + sx;
            a = sy * PW + sx;
            if (px + sx < SW && py + sy < SH && spr_mem[a] != 3'd0 && j + 2 <= upto) begin
               r = '{j + 2, px + sx, py + sy, int'(spr_mem[a]), -1, a};
               exp_q.push_back(r);
            end
         end
      end
   endtask

   // Runs one frame and records what the DUT shows; comparisons live in the test tasks.
   task automatic capture_frame(input int abort_at, input bit poke);
      int k;
      int k_end;
      int pb;
      int ps;
      rec_t r;
      obs_q.delete();
      done_q.delete();
      plot_after_abort = 1'b0;
      @(negedge clk);
      pb = int'(bg_addr);
      ps = int'(spr_addr);
      start = 1'b1;
      @(posedge clk);
      k = 0;
      k_end = (abort_at > 0) ? abort_at + 200 : 20000;
      while (k < k_end) begin
         @(negedge clk);
         k++;
         if (k == 1) start = 1'b0;
         if (plot) begin
            r = '{k, int'(x), int'(y), int'(colour), pb, ps};
            obs_q.push_back(r);
         end
         if (frame_done) begin
            if (done_q.size() == 0 && abort_at == 0) k_end = k + 20;
            done_q.push_back(k);
         end
         pb = int'(bg_addr);
         ps = int'(spr_addr);
         if (poke && k == 100) begin
            start = 1'b1;
            spr_x = 8'($urandom_range(0, 100));
            spr_y = 7'd0;
         end
         if (poke && k == 101) start = 1'b0;
         if (abort_at > 0 && k == abort_at) resetn = 1'b0;
         if (abort_at > 0 && k == abort_at + 1) begin
            plot_after_abort = plot;
            resetn = 1'b1;
         end
      end
      busy_end = busy;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      start  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (plot !== 1'b0)       begin errors++; $display("FAIL reset_plot got %0b exp 0", plot); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", frame_done); end
      checks++; if (bg_addr !== 18'd0)   begin errors++; $display("FAIL reset_bg_addr got %0d exp 0", bg_addr); end
      checks++; if (spr_addr !== 8'd0)   begin errors++; $display("FAIL reset_spr_addr got %0d exp 0", spr_addr); end
      checks++; if (x !== 8'd0)          begin errors++; $display("FAIL reset_x got %0d exp 0", x); end
      checks++; if (y !== 7'd0)          begin errors++; $display("FAIL reset_y got %0d exp 0", y); end
      checks++; if (colour !== 3'd0)     begin errors++; $display("FAIL reset_colour got %0d exp 0", colour); end
      start  = 1'b0;
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy got %0b exp 0", busy); end
      $display("test_reset: done");
   endtask

   task automatic test_full_frame;
      int n;
      int nbg;
      int nspr;
      int minx;
      int maxx;
      int miny;
      int maxy;
      for (int i = 0; i < NSPR; i++) spr_mem[i] = 3'd5;
      spr_x = 8'd20;
      spr_y = 7'd24;
      scroll_step = 11'd1838;
      capture_frame(0, 1'b0);
      build_model(0, 20, 24, 1 << 30);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL full_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      nbg = 0; nspr = 0; minx = 999; maxx = -1; miny = 999; maxy = -1;
      for (int i = 0; i < n; i++) begin
         checks++;
         if (obs_q[i].k != exp_q[i].k || obs_q[i].x != exp_q[i].x || obs_q[i].y != exp_q[i].y ||
             obs_q[i].c != exp_q[i].c || (exp_q[i].ba >= 0 && obs_q[i].ba != exp_q[i].ba) ||
             (exp_q[i].sa >= 0 && obs_q[i].sa != exp_q[i].sa)) begin
            errors++;
            $display("FAIL full_pix%0d got k=%0d x=%0d y=%0d c=%0d ba=%0d sa=%0d exp k=%0d x=%0d y=%0d c=%0d ba=%0d sa=%0d",
                     i, obs_q[i].k, obs_q[i].x, obs_q[i].y, obs_q[i].c, obs_q[i].ba, obs_q[i].sa,
                     exp_q[i].k, exp_q[i].x, exp_q[i].y, exp_q[i].c, exp_q[i].ba, exp_q[i].sa);
         end
      end
      foreach (obs_q[i]) begin
         if (obs_q[i].k < NBG + 2) nbg++;
         else begin
            nspr++;
            if (obs_q[i].x < minx) minx = obs_q[i].x;
            if (obs_q[i].x > maxx) maxx = obs_q[i].x;
            if (obs_q[i].y < miny) miny = obs_q[i].y;
            if (obs_q[i].y > maxy) maxy = obs_q[i].y;
         end
      end
      checks++; if (nbg != 19200) begin errors++; $display("FAIL bg_plots got %0d exp 19200", nbg); end
      checks++; if (obs_q.size() == 0 || obs_q[0].ba != 0 || obs_q[0].k != 2) begin errors++; $display("FAIL first_bg got addr/cycle mismatch (plots %0d) exp addr 0 cycle 2", obs_q.size()); end
      checks++; if (obs_q.size() < NBG || obs_q[NBG-1].ba != 119 * 2000 + 159) begin errors++; $display("FAIL last_bg_addr got plots %0d exp addr %0d", obs_q.size(), 119 * 2000 + 159); end
      checks++; if (done_q.size() != 1 || done_q[0] != 19443) begin errors++; $display("FAIL done_cycle got count %0d first %0d exp one at 19443", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1); end
      checks++; if (nspr != 240) begin errors++; $display("FAIL spr_plots got %0d exp 240", nspr); end
      checks++; if (minx != 20 || maxx != 34 || miny != 24 || maxy != 39) begin errors++; $display("FAIL spr_extent got x %0d..%0d y %0d..%0d exp x 20..34 y 24..39", minx, maxx, miny, maxy); end
      checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL full_busy_end got %0b exp 0", busy_end); end
      $display("test_full_frame: %0d plots, done at %0d", obs_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
   endtask

   task automatic test_clip_transparent;
      int n;
      int py;
      int ncol;
      bit seen [SW + PW];
      for (int i = 0; i < NSPR; i++) spr_mem[i] = 3'($urandom_range(1, 7));
      spr_mem[0] = 3'd0;
      py = int'($urandom_range(96, 118));
      spr_x = 8'd150;
      spr_y = 7'(py);
      scroll_step = 11'd5;
      capture_frame(0, 1'b1);
      build_model(1838, 150, py, 1 << 30);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL clip_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (obs_q[i].k != exp_q[i].k || obs_q[i].x != exp_q[i].x || obs_q[i].y != exp_q[i].y ||
             obs_q[i].c != exp_q[i].c || (exp_q[i].ba >= 0 && obs_q[i].ba != exp_q[i].ba) ||
             (exp_q[i].sa >= 0 && obs_q[i].sa != exp_q[i].sa)) begin
            errors++;
            $display("FAIL clip_pix%0d got k=%0d x=%0d y=%0d c=%0d ba=%0d sa=%0d exp k=%0d x=%0d y=%0d c=%0d ba=%0d sa=%0d",
                     i, obs_q[i].k, obs_q[i].x, obs_q[i].y, obs_q[i].c, obs_q[i].ba, obs_q[i].sa,
                     exp_q[i].k, exp_q[i].x, exp_q[i].y, exp_q[i].c, exp_q[i].ba, exp_q[i].sa);
         end
      end
      foreach (seen[i]) seen[i] = 1'b0;
      foreach (obs_q[i]) if (obs_q[i].k >= NBG + 2 && obs_q[i].x < SW + PW) seen[obs_q[i].x] = 1'b1;
      ncol = 0;
      foreach (seen[i]) if (seen[i]) ncol++;
      checks++; if (ncol != 10 || !seen[150] || !seen[159]) begin errors++; $display("FAIL clip_columns got %0d exp 10 (x 150..159)", ncol); end
      checks++; if (obs_q.size() > NBG && obs_q[NBG].k == NBG + 2) begin errors++; $display("FAIL transparent_pix0 got plot at cycle %0d exp none", NBG + 2); end
      checks++; if (done_q.size() != 1 || done_q[0] != LAST_K) begin errors++; $display("FAIL clip_done got count %0d exp one at %0d", done_q.size(), LAST_K); end
      checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL ignored_start busy_end got %0b exp 0", busy_end); end
      $display("test_clip_transparent: spr_y %0d, %0d plots", py, obs_q.size());
   endtask

   task automatic test_wrap_and_abort;
      int n;
      int px;
      int py;
      int late;
      px = int'($urandom_range(0, 159));
      py = int'($urandom_range(0, 119));
      spr_x = 8'(px);
      spr_y = 7'(py);
      scroll_step = 11'($urandom_range(0, 1840));
      capture_frame(5000, 1'b0);
      build_model(2, px, py, 5000);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (obs_q[i].k != exp_q[i].k || obs_q[i].x != exp_q[i].x || obs_q[i].y != exp_q[i].y ||
             obs_q[i].c != exp_q[i].c || (exp_q[i].ba >= 0 && obs_q[i].ba != exp_q[i].ba)) begin
            errors++;
            $display("FAIL wrap_pix%0d got k=%0d x=%0d y=%0d c=%0d ba=%0d exp k=%0d x=%0d y=%0d c=%0d ba=%0d",
                     i, obs_q[i].k, obs_q[i].x, obs_q[i].y, obs_q[i].c, obs_q[i].ba,
                     exp_q[i].k, exp_q[i].x, exp_q[i].y, exp_q[i].c, exp_q[i].ba);
         end
      end
      checks++; if (obs_q.size() == 0 || obs_q[0].ba != 2) begin errors++; $display("FAIL wrapped_offset got first addr %0d exp 2", (obs_q.size() > 0) ? obs_q[0].ba : -1); end
      late = 0;
      foreach (obs_q[i]) if (obs_q[i].k > 5000) late++;
      checks++; if (plot_after_abort !== 1'b0) begin errors++; $display("FAIL abort_plot got %0b exp 0", plot_after_abort); end
      checks++; if (late != 0) begin errors++; $display("FAIL plots_after_abort got %0d exp 0", late); end
      checks++; if (done_q.size() != 0) begin errors++; $display("FAIL abort_done got %0d pulses exp 0", done_q.size()); end
      checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b exp 0", busy_end); end
      $display("test_wrap_and_abort: %0d plots before abort", obs_q.size());
   endtask

   task automatic test_offset_cleared;
      capture_frame(3, 1'b0);
      build_model(0, 0, 0, 3);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL cleared_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
      checks++; if (obs_q.size() < 2 || obs_q[0].ba != 0 || obs_q[1].ba != 1) begin errors++; $display("FAIL cleared_offset got first addr %0d exp 0", (obs_q.size() > 0) ? obs_q[0].ba : -1); end
      checks++; if (done_q.size() != 0) begin errors++; $display("FAIL cleared_done got %0d pulses exp 0", done_q.size()); end
      $display("test_offset_cleared: %0d plots before abort", obs_q.size());
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_clip_transparent();
      test_wrap_and_abort();
      test_offset_cleared();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/scroll_frame_renderer.md
SCROLL_FRAME_RENDERER -- requirements
Module: scroll_frame_renderer

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, visible pixel columns.
REQ-002 SHALL have parameter SCREEN_H, default 120, visible pixel rows.
REQ-003 SHALL have parameter WORLD_W, default 2000, background ROM row pitch in pixels; WORLD_W >= SCREEN_W.
REQ-004 SHALL have parameter SPR_W, default 15, sprite columns.
REQ-005 SHALL have parameter SPR_H, default 16, sprite rows.
REQ-006 SHALL have parameter COLOR_W, default 3, colour bits.
REQ-007 SHALL have parameter TRANSPARENT, default 0, sprite colour that is never plotted.
REQ-008 The block SHALL use one clock; reset is synchronous and active-low: clk in 1, rising-edge clock.
REQ-009 resetn in 1, synchronous active-low reset.
REQ-010 start in 1, frame request pulse.
REQ-011 scroll_step in XW, where XW = clog2(WORLD_W), background advance applied at frame end.
REQ-012 spr_x in XS, where XS = clog2(SCREEN_W), sprite left column; spr_y in YS, where YS = clog2(SCREEN_H), sprite top row.
REQ-013 bg_addr out clog2(WORLD_W*SCREEN_H); bg_data in COLOR_W, one-cycle-latency ROM.
REQ-014 spr_addr out clog2(SPR_W*SPR_H); spr_data in COLOR_W, one-cycle-latency ROM.
REQ-015 x out XS, y out YS, colour out COLOR_W, plot out 1, VGA write port.
REQ-016 busy out 1, frame in progress; frame_done out 1, single-cycle pulse.

Function
REQ-017 FSM states: IDLE, BG, SPR, FLUSH, DONE; IDLE->BG on start; BG->SPR after last background pixel address; SPR->FLUSH after last sprite address; FLUSH->DONE after one cycle; DONE->IDLE unconditionally.
REQ-018 start SHALL be ignored unless the state is IDLE; busy=1 in BG, SPR, FLUSH and DONE.
REQ-019 BG SHALL issue one address per cycle, raster order (x fastest): bg_addr = offset + bx + by*WORLD_W.
REQ-020 SPR SHALL issue one address per cycle, raster order: spr_addr = sy*SPR_W + sx.
REQ-021 Pixel pipeline: coordinates and a valid bit issued with an address at cycle N SHALL appear on x/y/plot at cycle N+1, aligned with the ROM data on colour.
REQ-022 For start accepted at T: first bg_addr at T+1, first plot at T+2, frame_done at T+3+SCREEN_W*SCREEN_H+SPR_W*SPR_H.
REQ-023 Sprite pixel plot SHALL be suppressed when spr_data == TRANSPARENT, or spr_x+sx >= SCREEN_W, or spr_y+sy >= SCREEN_H (clipping); the address still advances.
REQ-024 spr_x, spr_y SHALL be latched at start acceptance; mid-frame changes have no effect.
REQ-025 offset range 0..MAXOFF, where MAXOFF = WORLD_W-SCREEN_W; in DONE, offset <= offset+scroll_step if <= MAXOFF, else offset+scroll_step-(MAXOFF+1) (wrap).
REQ-026 Offset arithmetic SHALL be performed at XW+1 bits to avoid overflow before the compare.
REQ-027 scroll_step is sampled in DONE only.
REQ-028 plot=0 whenever no valid pixel is in the pipeline stage.

Reset
REQ-029 resetn=0 at a clock edge SHALL force: state IDLE, offset 0, all counters 0, x=0, y=0, colour=0, plot=0, busy=0, frame_done=0, bg_addr=0, spr_addr=0.
REQ-030 Reset mid-frame SHALL abort the frame with no further plot and no frame_done.

Structure
REQ-031 FSM state encoding, the MAXOFF derivation and the address-width helper SHALL live in shared package render_pkg.
REQ-032 One sub-module, raster_counter (parametrised W, H; enable, clear; outputs col, row, last), SHALL be instantiated twice (background, sprite).

Verification
REQ-033 Defaults, offset 0, start pulse -> 19200 background plots, the first with bg_addr 0 and the last with bg_addr 119*2000+159; frame_done at T+19443.
REQ-034 Sprite ROM all 3'd5, spr_x=20, spr_y=24 -> 240 sprite plots covering x 20..34, y 24..39.
REQ-035 Sprite ROM with pixel 0 = 0 (TRANSPARENT), spr_x=150 -> no plot for the first sprite pixel; the columns for x>=160 are suppressed, leaving 10 columns (x 150..159) plotted.
REQ-036 offset 1838, scroll_step 5 -> next frame offset 2 (wrap: MAXOFF=1840).
REQ-037 start pulsed while busy -> ignored, no second frame; resetn low at 5000 cycles into a frame -> plot 0 on the next cycle, offset 0, frame_done never asserted.
